// File: rtl/sc_regbackgtype_bank.sv
// Background-type row bank for the road display: DEPTH scrolling rows fed from the
// data bus, a fixed fill value or a 16-bit LFSR, with a shift counter and wrap pulse.

module sc_regbackgtype_bank_chk #(
    parameter int CNTWIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    input logic [CNTWIDTH-1:0] cnt,
    input logic                wrap
);

    // A wrap pulse always coincides with a freshly wrapped counter and lasts one cycle.
    wrap_means_zero: assert property (@(posedge clk) disable iff (rst) wrap |-> (cnt == '0));
    wrap_one_cycle:  assert property (@(posedge clk) disable iff (rst) wrap |=> !wrap);

endmodule

module sc_regbackgtype_bank #(
    parameter int                              RegBACKGTYPE_DATAWIDTH  = 8,
    parameter int                              RegBACKGTYPE_DEPTH      = 4,
    parameter int                              RegBACKGTYPE_ADDRWIDTH  = 2,
    parameter int                              RegBACKGTYPE_CNTWIDTH   = 4,
    parameter logic [RegBACKGTYPE_DATAWIDTH-1:0] DATA_FIXED_INITREGBACKG = 8'b00000000,
    parameter logic [15:0]                     LFSR_SEED               = 16'hACE1
) (
    input  logic                              SC_RegBACKGTYPE_CLOCK_50,
    input  logic                              SC_RegBACKGTYPE_RESET_InHigh,
    input  logic                              SC_RegBACKGTYPE_clear_InLow,
    input  logic                              SC_RegBACKGTYPE_load_InLow,
    input  logic                              SC_RegBACKGTYPE_shift_InLow,
    input  logic                              SC_RegBACKGTYPE_mode_InHigh,
    input  logic [RegBACKGTYPE_ADDRWIDTH-1:0] SC_RegBACKGTYPE_rowsel_InBUS,
    input  logic [RegBACKGTYPE_DATAWIDTH-1:0] SC_RegBACKGTYPE_data_InBUS,
    output logic [RegBACKGTYPE_DATAWIDTH-1:0] SC_RegBACKGTYPE_data_OutBUS_2REG,
    output logic [RegBACKGTYPE_DATAWIDTH-1:0] SC_RegBACKGTYPE_data_OutBUS_2DISP,
    output logic [RegBACKGTYPE_CNTWIDTH-1:0]  SC_RegBACKGTYPE_shiftcnt_OutBUS,
    output logic                              SC_RegBACKGTYPE_wrap_OutHigh
);

    localparam int DW    = RegBACKGTYPE_DATAWIDTH;
    localparam int DEPTH = RegBACKGTYPE_DEPTH;
    localparam int AW    = RegBACKGTYPE_ADDRWIDTH;
    localparam int CW    = RegBACKGTYPE_CNTWIDTH;

    // Fibonacci right-shift LFSR, taps 16/14/13/11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
        return {fb, cur[15:1]};
    endfunction

    logic [DW-1:0] rows_r [DEPTH];
    logic [DW-1:0] rows_s [DEPTH];
    logic [15:0]   lfsr_r;
    logic [15:0]   lfsr_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          wrap_r;
    logic          wrap_s;
    logic [DW-1:0] disp_s;

    // Next-state: clear beats shift, shift beats a plain load, otherwise hold.
    always_comb begin
        rows_s = rows_r;
        lfsr_s = lfsr_r;
        cnt_s  = cnt_r;
        wrap_s = 1'b0;
        if (!SC_RegBACKGTYPE_clear_InLow) begin
            for (int i = 0; i < DEPTH; i++) begin
                rows_s[i] = DATA_FIXED_INITREGBACKG;
            end
            lfsr_s = LFSR_SEED;
            cnt_s  = '0;
        end else if (!SC_RegBACKGTYPE_shift_InLow) begin
            for (int i = 1; i < DEPTH; i++) begin
                rows_s[i] = rows_r[i-1];
            end
            if (!SC_RegBACKGTYPE_load_InLow) begin
                rows_s[0] = SC_RegBACKGTYPE_data_InBUS;
            end else if (SC_RegBACKGTYPE_mode_InHigh) begin
                // Inserted row takes the pre-advance pattern.
                rows_s[0] = lfsr_r[DW-1:0];
                lfsr_s    = lfsr_next(lfsr_r);
            end else begin
                rows_s[0] = DATA_FIXED_INITREGBACKG;
            end
            cnt_s  = cnt_r + CW'(1'b1);
            wrap_s = (cnt_r == {CW{1'b1}});
        end else if (!SC_RegBACKGTYPE_load_InLow) begin
            rows_s[0] = SC_RegBACKGTYPE_data_InBUS;
        end else begin
            rows_s = rows_r;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            for (int i = 0; i < DEPTH; i++) begin
                rows_r[i] <= '0;
            end
            lfsr_r <= LFSR_SEED;
            cnt_r  <= '0;
            wrap_r <= 1'b0;
        end else begin
            rows_r <= rows_s;
            lfsr_r <= lfsr_s;
            cnt_r  <= cnt_s;
            wrap_r <= wrap_s;
        end
    end

    // Display row mux; unmatched selects (rowsel >= DEPTH) read as zero.
    always_comb begin
        disp_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            disp_s = disp_s | ((SC_RegBACKGTYPE_rowsel_InBUS == AW'(i)) ? rows_r[i] : '0);
        end
    end

    assign SC_RegBACKGTYPE_data_OutBUS_2REG  = rows_r[DEPTH-1];
    assign SC_RegBACKGTYPE_data_OutBUS_2DISP = disp_s;
    assign SC_RegBACKGTYPE_shiftcnt_OutBUS   = cnt_r;
    assign SC_RegBACKGTYPE_wrap_OutHigh      = wrap_r;

    sc_regbackgtype_bank_chk #(
        .CNTWIDTH (CW)
    ) u_chk (
        .clk  (SC_RegBACKGTYPE_CLOCK_50),
        .rst  (SC_RegBACKGTYPE_RESET_InHigh),
        .cnt  (cnt_r),
        .wrap (wrap_r)
    );

endmodule
